// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: default widths, skid-stage state and payload layout.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned RADDR_W_DEF = 5;
  localparam int unsigned ALUOP_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // Field order matches the flat vector packed by id_ex_skid_stage (MSB first).
  typedef struct packed {
    logic                   regfile_we;
    logic [RADDR_W_DEF-1:0] regfile_waddr;
    logic [ALUOP_W_DEF-1:0] alu_op;
    logic [DATA_W_DEF-1:0]  alu_src1;
    logic [DATA_W_DEF-1:0]  alu_src2;
    logic                   mem_re;
    logic                   mem_we;
  } id_ex_payload_t;

  function automatic int unsigned payload_width(input int unsigned data_w,
                                                input int unsigned raddr_w,
                                                input int unsigned aluop_w);
    return 3 + raddr_w + aluop_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/pipe_payload_slot.sv
// One payload register with load enable; cleared by synchronous active-low reset.
module pipe_payload_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Capture on load, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// Two-entry elastic ID/EX stage (main + skid slot) with registered in_ready and flush.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_regfile_we,
  input  logic [RADDR_W-1:0] in_regfile_waddr,
  input  logic [ALUOP_W-1:0] in_alu_op,
  input  logic [DATA_W-1:0]  in_alu_src1,
  input  logic [DATA_W-1:0]  in_alu_src2,
  input  logic               in_mem_re,
  input  logic               in_mem_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_regfile_we,
  output logic [RADDR_W-1:0] out_regfile_waddr,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic [DATA_W-1:0]  out_alu_src1,
  output logic [DATA_W-1:0]  out_alu_src2,
  output logic               out_mem_re,
  output logic               out_mem_we,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int unsigned PW = payload_width(DATA_W, RADDR_W, ALUOP_W);

  stage_state_t state_q, state_d;
  logic         in_ready_q;
  logic         accept, drain;
  logic         main_load, skid_load, main_from_skid;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;
  logic         main_regfile_we, main_mem_re, main_mem_we;

  assign in_payload = {in_regfile_we, in_regfile_waddr, in_alu_op, in_alu_src1, in_alu_src2,
                       in_mem_re, in_mem_we};

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  // Next state and slot load enables; flush overrides everything but reset.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_payload;

  // State and registered ready; ready derives from next state so no comb path from out_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  pipe_payload_slot #(
    .W (PW)
  ) u_main_slot (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_payload_slot #(
    .W (PW)
  ) u_skid_slot (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .d_i    (in_payload),
    .q_o    (skid_q)
  );

  assign {main_regfile_we, out_regfile_waddr, out_alu_op, out_alu_src1, out_alu_src2,
          main_mem_re, main_mem_we} = main_q;

  // Bubbles must never write state; data fields stay put to avoid toggling.
  assign out_regfile_we = main_regfile_we & out_valid;
  assign out_mem_re     = main_mem_re & out_valid;
  assign out_mem_we     = main_mem_we & out_valid;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall and squash counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (state_q != EMPTY) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: expected payloads are queued at issue and
// popped by a monitor on every drain; directed checks cover ready, squash and counters.
module tb_id_ex_skid_stage;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 8;
  localparam int unsigned CW = 3;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic          in_regfile_we, in_mem_re, in_mem_we;
  logic [AW-1:0] in_regfile_waddr;
  logic [OW-1:0] in_alu_op;
  logic [DW-1:0] in_alu_src1, in_alu_src2;
  logic          out_valid, out_ready;
  logic          out_regfile_we, out_mem_re, out_mem_we;
  logic [AW-1:0] out_regfile_waddr;
  logic [OW-1:0] out_alu_op;
  logic [DW-1:0] out_alu_src1, out_alu_src2;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  id_ex_payload_t exp_q[$];
  id_ex_payload_t mon_e;

  always #5 clk = ~clk;

  id_ex_skid_stage #(
    .DATA_W  (DW),
    .RADDR_W (AW),
    .ALUOP_W (OW),
    .CNT_W   (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_regfile_we     (in_regfile_we),
    .in_regfile_waddr  (in_regfile_waddr),
    .in_alu_op         (in_alu_op),
    .in_alu_src1       (in_alu_src1),
    .in_alu_src2       (in_alu_src2),
    .in_mem_re         (in_mem_re),
    .in_mem_we         (in_mem_we),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_regfile_we    (out_regfile_we),
    .out_regfile_waddr (out_regfile_waddr),
    .out_alu_op        (out_alu_op),
    .out_alu_src1      (out_alu_src1),
    .out_alu_src2      (out_alu_src2),
    .out_mem_re        (out_mem_re),
    .out_mem_we        (out_mem_we),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic id_ex_payload_t mk(input logic [31:0] s1);
    id_ex_payload_t p;
    p.regfile_we    = 1'b1;
    p.regfile_waddr = s1[4:0];
    p.alu_op        = s1[7:0] ^ 8'h5a;
    p.alu_src1      = s1;
    p.alu_src2      = ~s1;
    p.mem_re        = s1[0];
    p.mem_we        = s1[1];
    return p;
  endfunction

  task automatic drive(input logic v, input id_ex_payload_t p);
    in_valid         = v;
    in_regfile_we    = p.regfile_we;
    in_regfile_waddr = p.regfile_waddr;
    in_alu_op        = p.alu_op;
    in_alu_src1      = p.alu_src1;
    in_alu_src2      = p.alu_src2;
    in_mem_re        = p.mem_re;
    in_mem_we        = p.mem_we;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every drain must match the oldest outstanding expected payload.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_drain: got src1 %0h expected no output", out_alu_src1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_src1", 96'(out_alu_src1), 96'(mon_e.alu_src1));
        chk("drain_src2", 96'(out_alu_src2), 96'(mon_e.alu_src2));
        chk("drain_ctrl",
            96'({out_regfile_we, out_regfile_waddr, out_alu_op, out_mem_re, out_mem_we}),
            96'({mon_e.regfile_we, mon_e.regfile_waddr, mon_e.alu_op, mon_e.mem_re,
                 mon_e.mem_we}));
      end
    end
  end

  initial begin
    id_ex_payload_t p, pa, pb, pc, pe;

    // Reset held with input offered.
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, mk(32'h99));
    repeat (3) cyc();
    chk("rst_valid", 96'(out_valid), 96'(0));
    chk("rst_ready", 96'(in_ready), 96'(0));
    chk("rst_src1", 96'(out_alu_src1), 96'(0));
    chk("rst_ctrl", 96'({out_regfile_waddr, out_alu_op, out_regfile_we, out_mem_we}), 96'(0));
    rst = 1'b1;
    drive(1'b0, mk(32'h0));
    cyc();
    chk("rel_ready", 96'(in_ready), 96'(1));
    chk("rel_valid", 96'(out_valid), 96'(0));

    // Streaming, one-cycle latency, no bubbles.
    for (int i = 0; i < 4; i++) begin
      p = mk(32'h11 * (i + 1));
      drive(1'b1, p);
      exp_q.push_back(p);
      cyc();
      chk("stream_valid", 96'(out_valid), 96'(1));
      chk("stream_src1", 96'(out_alu_src1), 96'(p.alu_src1));
      chk("stream_ready", 96'(in_ready), 96'(1));
    end
    drive(1'b0, mk(32'h0));
    cyc();
    chk("stream_empty", 96'(out_valid), 96'(0));

    // Back-pressure: A held, B skids, C refused until drain.
    out_ready = 1'b0;
    pa = mk(32'hA);
    pb = mk(32'hB);
    pc = mk(32'hC);
    drive(1'b1, pa);
    exp_q.push_back(pa);
    cyc();
    chk("bp_a_src1", 96'(out_alu_src1), 96'(32'hA));
    chk("bp_a_ready", 96'(in_ready), 96'(1));
    drive(1'b1, pb);
    exp_q.push_back(pb);
    cyc();
    chk("bp_full_ready", 96'(in_ready), 96'(0));
    drive(1'b1, pc);
    repeat (4) begin
      cyc();
      chk("bp_hold_ready", 96'(in_ready), 96'(0));
      chk("bp_hold_src1", 96'(out_alu_src1), 96'(32'hA));
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_b_src1", 96'(out_alu_src1), 96'(32'hB));
    chk("bp_b_ready", 96'(in_ready), 96'(1));
    exp_q.push_back(pc);
    cyc();
    chk("bp_c_src1", 96'(out_alu_src1), 96'(32'hC));
    drive(1'b0, mk(32'h0));
    cyc();
    chk("bp_empty", 96'(out_valid), 96'(0));
    chk("stall_cnt_5", 96'(stall_cnt), PERF ? 96'(5) : 96'(0));
    chk("flush_cnt_0", 96'(flush_cnt), 96'(0));

    // Flush while TWO with a new input offered.
    out_ready = 1'b0;
    pe = mk(32'hE);
    drive(1'b1, pe);
    exp_q.push_back(pe);
    cyc();
    drive(1'b1, mk(32'hF));
    exp_q.push_back(mk(32'hF));
    cyc();
    chk("fl_two_ready", 96'(in_ready), 96'(0));
    drive(1'b1, mk(32'hD));
    flush = 1'b1;
    exp_q.delete();
    cyc();
    flush = 1'b0;
    drive(1'b0, mk(32'h0));
    chk("fl_valid", 96'(out_valid), 96'(0));
    chk("fl_we", 96'(out_regfile_we), 96'(0));
    chk("fl_ready", 96'(in_ready), 96'(1));
    chk("fl_src1_hold", 96'(out_alu_src1), 96'(32'hE));
    chk("flush_cnt_1", 96'(flush_cnt), PERF ? 96'(1) : 96'(0));
    chk("stall_cnt_7", 96'(stall_cnt), PERF ? 96'(7) : 96'(0));
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("fl_d_absent", 96'(out_valid), 96'(0));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_empty_cnt", 96'(flush_cnt), PERF ? 96'(1) : 96'(0));

    // Bubble squash of side-effecting controls.
    p = mk(32'h2);
    drive(1'b1, p);
    exp_q.push_back(p);
    cyc();
    chk("bub_live_ctrl", 96'({out_regfile_we, out_mem_we}), 96'(2'b11));
    drive(1'b0, mk(32'h0));
    cyc();
    chk("bub_valid", 96'(out_valid), 96'(0));
    chk("bub_ctrl", 96'({out_regfile_we, out_mem_re, out_mem_we}), 96'(0));
    chk("bub_src1", 96'(out_alu_src1), 96'(32'h2));
    cyc();
    chk("bub_src1_hold", 96'(out_alu_src1), 96'(32'h2));

    // Counter saturation at all-ones (CW=3).
    out_ready = 1'b0;
    drive(1'b1, mk(32'h55));
    cyc();
    drive(1'b0, mk(32'h0));
    repeat (2) cyc();
    chk("stall_sat", 96'(stall_cnt), PERF ? 96'(7) : 96'(0));
    for (int k = 0; k < 7; k++) begin
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b1, mk(32'h60 + k));
      cyc();
      drive(1'b0, mk(32'h0));
    end
    chk("flush_sat", 96'(flush_cnt), PERF ? 96'(7) : 96'(0));

    // Reset while two entries are held.
    drive(1'b1, mk(32'h77));
    cyc();
    chk("mid_two_ready", 96'(in_ready), 96'(0));
    rst = 1'b0;
    drive(1'b0, mk(32'h0));
    cyc();
    chk("mid_rst_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_ready", 96'(in_ready), 96'(0));
    chk("mid_rst_src1", 96'(out_alu_src1), 96'(0));
    rst = 1'b1;
    cyc();
    chk("mid_rel_ready", 96'(in_ready), 96'(1));
    chk("mid_rel_cnts", 96'({stall_cnt, flush_cnt}), 96'(0));

    chk("queue_empty", 96'(exp_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
